// File: rtl/fp_add_sequencer.sv
// Floating-point add controller: time-shares one external add/subtract datapath
// through exponent compare, mantissa align, add/subtract and normalize steps.
module fp_add_sequencer #(
  parameter int unsigned EXP_W = 8,
  parameter int unsigned MAN_W = 23,
  parameter int unsigned ADD_W = MAN_W + 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [EXP_W+MAN_W:0]     in_a,
  input  logic [EXP_W+MAN_W:0]     in_b,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [EXP_W+MAN_W:0]     out_sum,
  output logic                     busy,
  output logic [ADD_W-1:0]         add_a,
  output logic [ADD_W-1:0]         add_b,
  output logic                     add_op,
  input  logic [ADD_W-1:0]         add_c,
  input  logic                     add_cout,
  input  logic                     add_cpenult
);

  localparam int unsigned SW = EXP_W + MAN_W + 1;

  typedef enum logic [2:0] {
    IDLE, EXP_CMP, EXP_SWP, MAN_CMP, ALIGN, MAN_ADD, NORM, DONE
  } state_t;

  state_t             state, state_d;
  logic               sa, sb, sa_d, sb_d;
  logic [EXP_W-1:0]   ea, eb, ea_d, eb_d;
  logic [ADD_W-1:0]   ma, mb, ma_d, mb_d;
  logic [ADD_W-1:0]   diff, diff_d;
  logic [ADD_W-1:0]   m_sh;
  logic [EXP_W-1:0]   e_new;
  logic [SW-1:0]      out_sum_d;
  logic [ADD_W-1:0]   add_a_d, add_b_d;
  logic               add_op_d;
  logic               unused_cpenult;

  assign unused_cpenult = add_cpenult;

  // Mantissa with hidden bit restored; a zero exponent encodes the value zero.
  function automatic logic [ADD_W-1:0] mant(input logic [SW-1:0] x);
    if (x[MAN_W +: EXP_W] == '0) return '0;
    return ADD_W'({1'b1, x[MAN_W-1:0]});
  endfunction

  always_comb begin
    state_d   = state;
    sa_d      = sa;
    sb_d      = sb;
    ea_d      = ea;
    eb_d      = eb;
    ma_d      = ma;
    mb_d      = mb;
    diff_d    = diff;
    out_sum_d = out_sum;
    add_a_d   = '0;
    add_b_d   = '0;
    add_op_d  = 1'b0;
    m_sh      = '0;
    e_new     = add_c[EXP_W-1:0];

    // add_* are registered, so each branch sets up the adder for the next state.
    case (state)
      IDLE: begin
        if (in_valid) begin
          sa_d     = in_a[SW-1];
          sb_d     = in_b[SW-1];
          ea_d     = in_a[MAN_W +: EXP_W];
          eb_d     = in_b[MAN_W +: EXP_W];
          ma_d     = mant(in_a);
          mb_d     = mant(in_b);
          add_a_d  = ADD_W'(in_a[MAN_W +: EXP_W]);
          add_b_d  = ADD_W'(in_b[MAN_W +: EXP_W]);
          add_op_d = 1'b1;
          state_d  = EXP_CMP;
        end
      end
      EXP_CMP: begin
        add_op_d = 1'b1;
        if (add_c == '0) begin
          add_a_d = ma;
          add_b_d = mb;
          state_d = MAN_CMP;
        end else if (add_cout) begin
          diff_d  = add_c;
          add_a_d = add_c;
          add_b_d = ADD_W'(1);
          state_d = ALIGN;
        end else begin
          sa_d    = sb;
          sb_d    = sa;
          ea_d    = eb;
          eb_d    = ea;
          ma_d    = mb;
          mb_d    = ma;
          add_a_d = ADD_W'(eb);
          add_b_d = ADD_W'(ea);
          state_d = EXP_SWP;
        end
      end
      EXP_SWP: begin
        diff_d   = add_c;
        add_a_d  = add_c;
        add_b_d  = ADD_W'(1);
        add_op_d = 1'b1;
        state_d  = ALIGN;
      end
      MAN_CMP: begin
        if (!add_cout) begin
          sa_d = sb;
          sb_d = sa;
          ma_d = mb;
          mb_d = ma;
        end
        add_a_d  = add_cout ? ma : mb;
        add_b_d  = add_cout ? mb : ma;
        add_op_d = sa ^ sb;
        state_d  = MAN_ADD;
      end
      ALIGN: begin
        mb_d   = mb >> 1;
        diff_d = add_c;
        if (add_c == '0 || mb_d == '0) begin
          add_a_d  = ma;
          add_b_d  = mb_d;
          add_op_d = sa ^ sb;
          state_d  = MAN_ADD;
        end else begin
          add_a_d  = add_c;
          add_b_d  = ADD_W'(1);
          add_op_d = 1'b1;
        end
      end
      MAN_ADD: begin
        ma_d = add_c;
        if (add_c == '0) begin
          out_sum_d = '0;
          state_d   = DONE;
        end else begin
          state_d = NORM;
          if (add_c[MAN_W+1]) begin
            add_a_d  = ADD_W'(ea);
            add_b_d  = ADD_W'(1);
            add_op_d = 1'b0;
          end else if (!add_c[MAN_W]) begin
            add_a_d  = ADD_W'(ea);
            add_b_d  = ADD_W'(1);
            add_op_d = 1'b1;
          end
        end
      end
      NORM: begin
        // The shift commits here; if that leaves m normalized the result is final.
        if (ma[MAN_W+1]) begin
          m_sh    = ma >> 1;
          ma_d    = m_sh;
          ea_d    = e_new;
          state_d = DONE;
          if (&e_new) out_sum_d = {sa, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
          else        out_sum_d = {sa, e_new, m_sh[MAN_W-1:0]};
        end else if (!ma[MAN_W]) begin
          m_sh = ma << 1;
          ma_d = m_sh;
          ea_d = e_new;
          if (e_new == '0) begin
            out_sum_d = '0;
            state_d   = DONE;
          end else if (m_sh[MAN_W]) begin
            out_sum_d = {sa, e_new, m_sh[MAN_W-1:0]};
            state_d   = DONE;
          end else begin
            add_a_d  = ADD_W'(e_new);
            add_b_d  = ADD_W'(1);
            add_op_d = 1'b1;
          end
        end else begin
          out_sum_d = {sa, ea, ma[MAN_W-1:0]};
          state_d   = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      sa        <= 1'b0;
      sb        <= 1'b0;
      ea        <= '0;
      eb        <= '0;
      ma        <= '0;
      mb        <= '0;
      diff      <= '0;
      out_sum   <= '0;
      add_a     <= '0;
      add_b     <= '0;
      add_op    <= 1'b0;
      in_ready  <= 1'b1;
      busy      <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      state     <= state_d;
      sa        <= sa_d;
      sb        <= sb_d;
      ea        <= ea_d;
      eb        <= eb_d;
      ma        <= ma_d;
      mb        <= mb_d;
      diff      <= diff_d;
      out_sum   <= out_sum_d;
      add_a     <= add_a_d;
      add_b     <= add_b_d;
      add_op    <= add_op_d;
      in_ready  <= (state_d == IDLE);
      busy      <= (state_d != IDLE);
      out_valid <= (state_d == DONE);
    end
  end

endmodule

// File: tb/tb_fp_add_sequencer.sv
// Directed bench for fp_add_sequencer with a behavioural ripple adder model.
module tb_fp_add_sequencer;

  localparam int unsigned EXP_W = 8;
  localparam int unsigned MAN_W = 23;
  localparam int unsigned ADD_W = MAN_W + 2;
  localparam int unsigned SW    = EXP_W + MAN_W + 1;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [SW-1:0]    in_a, in_b;
  logic             out_valid;
  logic             out_ready;
  logic [SW-1:0]    out_sum;
  logic             busy;
  logic [ADD_W-1:0] add_a, add_b, add_c, bb;
  logic             add_op, add_cout, add_cpenult;
  logic [ADD_W:0]   full;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  // Adder model: a + b, or a + ~b + 1 when subtracting.
  always_comb begin
    bb   = add_op ? ~add_b : add_b;
    full = {1'b0, add_a} + {1'b0, bb} + (ADD_W+1)'(add_op);
  end
  assign add_c       = full[ADD_W-1:0];
  assign add_cout    = full[ADD_W];
  assign add_cpenult = add_c[ADD_W-1] ^ add_a[ADD_W-1] ^ bb[ADD_W-1];

  fp_add_sequencer #(.EXP_W(EXP_W), .MAN_W(MAN_W), .ADD_W(ADD_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum), .busy(busy),
    .add_a(add_a), .add_b(add_b), .add_op(add_op),
    .add_c(add_c), .add_cout(add_cout), .add_cpenult(add_cpenult)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Issue one operation, wait for the result, optionally stall the sink, then consume.
  task automatic run_op(input string tag, input logic [SW-1:0] a, input logic [SW-1:0] b,
                        input logic [SW-1:0] exp_sum, input int exp_lat, input int hold);
    int lat;
    logic [SW-1:0] first;
    @(negedge clk);
    check({tag, " in_ready"}, 64'(in_ready), 64'd1);
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    check({tag, " busy"}, 64'(busy), 64'd1);
    while (!out_valid && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    check({tag, " out_valid"}, 64'(out_valid), 64'd1);
    if (exp_lat > 0) check({tag, " latency"}, 64'(lat), 64'(exp_lat));
    check({tag, " sum"}, 64'(out_sum), 64'(exp_sum));
    check({tag, " add_a idle in DONE"}, 64'({add_a, add_b, add_op}), 64'd0);
    first = out_sum;
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1;
      in_a     = 32'h3F800000;
      in_b     = 32'h3F800000;
      @(negedge clk);
      check({tag, " hold sum"}, 64'(out_sum), 64'(first));
      check({tag, " hold in_ready"}, 64'(in_ready), 64'd0);
      check({tag, " hold out_valid"}, 64'(out_valid), 64'd1);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, " consumed"}, 64'({out_valid, in_ready, busy}), 64'b010);
  endtask

  initial begin
    int seen;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_a      = '0;
    in_b      = '0;
    #12;
    check("reset outputs", 64'({in_ready, out_valid, busy, add_op}), 64'b1000);
    check("reset sum", 64'(out_sum), 64'd0);
    check("reset add", 64'({add_a, add_b}), 64'd0);
    rst_n = 1'b1;

    run_op("1+1",        32'h3F800000, 32'h3F800000, 32'h40000000, 5, 0);
    run_op("3+-1",       32'h40400000, 32'hBF800000, 32'h40000000, 5, 0);
    run_op("1+-1",       32'h3F800000, 32'hBF800000, 32'h00000000, 4, 0);
    run_op("1+2^24",     32'h3F800000, 32'h4B800000, 32'h4B800000, 29, 0);
    run_op("max+max",    32'h7F7FFFFF, 32'h7F7FFFFF, 32'h7F800000, 5, 0);
    run_op("1.5-1.25",   32'h3FC00000, 32'hBFA00000, 32'h3E800000, 6, 0);
    run_op("1-1.5",      32'h3F800000, 32'hBFC00000, 32'hBF000000, 5, 0);
    run_op("0+2",        32'h00000000, 32'h40000000, 32'h40000000, 6, 0);
    run_op("hold",       32'h40400000, 32'hBF800000, 32'h40000000, 5, 10);

    // Reset while ALIGN is running: immediate reset values, no result afterwards.
    @(negedge clk);
    in_valid = 1'b1;
    in_a     = 32'h3F800000;
    in_b     = 32'h4B800000;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (5) @(negedge clk);
    check("pre-reset busy", 64'(busy), 64'd1);
    rst_n = 1'b0;
    #1;
    check("mid reset flags", 64'({in_ready, out_valid, busy}), 64'b100);
    check("mid reset sum", 64'(out_sum), 64'd0);
    check("mid reset add", 64'({add_a, add_b, add_op}), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    check("no result after reset", 64'(seen), 64'd0);
    run_op("post-reset", 32'h3F800000, 32'h3F800000, 32'h40000000, 5, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fp_add_sequencer.md
Name: fp_add_sequencer

Overview:
- Multi-cycle controller that performs one floating-point addition by time-sharing a single external N-bit ripple add/subtract datapath.
- Sequence: exponent compare, mantissa align, mantissa add/subtract, normalize.
- Sits between operand source and result sink with valid/ready handshakes on both sides.
- Owns the adder's operand, op and carry inputs; no arithmetic beyond shifts and muxing is done locally.

Parameters:
- EXP_W, 8, exponent field width.
- MAN_W, 23, stored fraction width; hidden bit restored internally.
- ADD_W, MAN_W+2, width of shared adder. Must satisfy ADD_W >= EXP_W.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  high only in IDLE.
- in_a  in  EXP_W+MAN_W+1  operand A, fields {sign, exp, frac}.
- in_b  in  EXP_W+MAN_W+1  operand B, fields {sign, exp, frac}.
- out_valid  out  1  result valid.
- out_ready  in  1  sink accepts result.
- out_sum  out  EXP_W+MAN_W+1  result.
- busy  out  1  high in every state except IDLE.
- add_a  out  ADD_W  adder operand a.
- add_b  out  ADD_W  adder operand b.
- add_op  out  1  0 = a+b, 1 = a-b. Carry-in equals op.
- add_c  in  ADD_W  adder sum.
- add_cout  in  1  adder carry out. In subtract mode, 1 means a>=b.
- add_cpenult  in  1  carry into MSB; unused, reserved.

Behaviour:
- Reset (async, rst_n=0): state IDLE; in_ready=1, out_valid=0, busy=0, out_sum=0; add_a, add_b and add_op all 0. All internal registers cleared.
- Reset mid-operation: the operation is discarded and no result is emitted.
- Adder is combinational: drive add_* in a state and sample add_c/add_cout at the end of the same cycle.
- Exponents are zero-extended to ADD_W.
- Operand decode:
  - exp==0 means value zero; mantissa = 0, with no hidden bit.
  - Otherwise mantissa = {0, 1, frac} on ADD_W bits.
  - Exponent all-ones is not special on input; NaN/denormals are not supported.
- States:
  - IDLE: in_ready=1. On in_valid, latch operands → EXP_CMP.
  - EXP_CMP: drive ea-eb, op=1.
    - c==0 → MAN_CMP.
    - cout=1, c>0: A is larger; diff=c → ALIGN.
    - cout=0: swap A/B → EXP_SWP.
  - EXP_SWP: drive eb-ea, op=1; diff=c → ALIGN.
  - MAN_CMP: drive ma-mb, op=1. If cout=0, swap so A holds the larger magnitude → MAN_ADD.
  - ALIGN: each cycle shift mb right by 1, drive diff-1 (op=1), diff=c.
    - Exit to MAN_ADD when the new diff==0 or the shifted mb==0.
    - Shifted-out bits are discarded (truncation).
  - MAN_ADD: drive ma±mb, with op = sa XOR sb; m=c; result exponent e=ea; result sign = sa.
    - m==0 → result +0 → DONE.
    - Otherwise → NORM.
  - NORM, one action per cycle:
    - If m[MAN_W+1]: m>>=1 and drive e+1 (op=0). If the new e is all-ones → result ±infinity (frac=0) → DONE.
    - Else if !m[MAN_W]: m<<=1 and drive e-1 (op=1). If the new e==0 → result +0 (flush) → DONE.
    - Else result = {sign, e, m[MAN_W-1:0]} → DONE.
  - DONE: out_valid=1 and out_sum held stable. On out_ready → IDLE. in_valid is ignored here.
- Latency from accept (IDLE cycle with in_valid high):
  - Stages: 1 (EXP_CMP), +1 (EXP_SWP or MAN_CMP if taken), +align cycles (≤ MAN_W+1), +1 (MAN_ADD), +norm cycles (≤ MAN_W+1).
  - out_valid is asserted in the cycle after the final NORM.
- Operands are only accepted in IDLE.
- Simultaneous out_ready and in_valid in DONE: the result is consumed; the new input is accepted no earlier than the next IDLE cycle.
- add_* outputs are 0 in IDLE and DONE.

Test Plan:
- 0x3F800000 + 0x3F800000 → 0x40000000.
  - Path: MAN_CMP taken, one right-normalize; out_valid 5 cycles after accept.
- 0x40400000 + 0xBF800000 (3 + -1) → 0x40000000. EXP_SWP not taken, one align cycle.
- 0x3F800000 + 0xBF800000 → 0x00000000. Zero detected in MAN_ADD; no NORM cycles.
- 0x3F800000 + 0x4B800000 (1 + 2^24) → 0x4B800000.
  - EXP_SWP taken; ALIGN exits early when mb reaches 0 after 24 shifts.
- 0x7F7FFFFF + 0x7F7FFFFF → 0x7F800000 (overflow to +infinity).
- Handshake and reset:
  - Hold out_ready=0 for 10 cycles in DONE: out_sum is stable and in_ready stays 0.
  - Assert rst_n=0 during ALIGN: all outputs take reset values immediately and no out_valid follows.
